// File: rtl/spatz_spm_partition_ctrl.sv
// SPM/cache split controller: drains per-port traffic, flushes the cache,
// then commits the new SPM size to the address mapper.
module spatz_spm_partition_ctrl #(
  parameter int unsigned NumIO          = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned SizeGranule    = 1024,
  parameter logic [AddrWidth-1:0] SpmSizeReset = 'h0001_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [AddrWidth-1:0] cfg_spm_size_i,
  input  logic [AddrWidth-1:0] tcdm_start_address_i,
  input  logic [AddrWidth-1:0] tcdm_end_address_i,
  output logic [AddrWidth-1:0] spm_size_o,
  input  logic [NumIO-1:0]     req_valid_i,
  input  logic [NumIO-1:0]     req_ready_i,
  input  logic [NumIO-1:0]     rsp_valid_i,
  output logic [NumIO-1:0]     stall_o,
  output logic                 cache_flush_valid_o,
  input  logic                 cache_flush_ready_i,
  input  logic                 cache_flush_done_i,
  output logic                 busy_o,
  output logic                 cfg_error_o,
  output logic                 underflow_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] GranMask = AddrWidth'(SizeGranule - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    FLUSH_REQ,
    FLUSH_WAIT,
    COMMIT
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [CntW-1:0]      r_cnt     [NumIO];
  logic [CntW-1:0]      w_cnt_nxt [NumIO];
  logic [NumIO-1:0]     w_uf;
  logic                 w_all_zero;
  logic [AddrWidth-1:0] r_spm;
  logic [AddrWidth-1:0] r_pending;
  logic                 r_cfg_err;
  logic                 r_uf;
  logic [AddrWidth-1:0] w_region;
  logic                 w_idle;
  logic                 w_cfg_hs;
  logic                 w_size_ok;
  logic                 w_accept;

  assign w_idle    = (r_state == IDLE);
  assign w_region  = tcdm_end_address_i - tcdm_start_address_i;
  assign w_cfg_hs  = cfg_valid_i & w_idle;
  assign w_size_ok = (cfg_spm_size_i <= w_region) &&
                     ((cfg_spm_size_i & GranMask) == '0);
  assign w_accept  = w_cfg_hs & w_size_ok &
                     (cfg_spm_size_i != r_spm);

  // Drain exits on the next-cycle counts so the last response
  // and the move to FLUSH_REQ share a cycle.
  always_comb begin
    w_all_zero = 1'b1;
    w_uf       = '0;
    for (int j = 0; j < NumIO; j++) begin
      w_cnt_nxt[j] = r_cnt[j];
      if (req_valid_i[j] & req_ready_i[j] & ~rsp_valid_i[j]) begin
        w_cnt_nxt[j] = r_cnt[j] + CntW'(1);
      end else if (rsp_valid_i[j] & ~(req_valid_i[j] & req_ready_i[j])) begin
        if (r_cnt[j] == '0) begin
          w_uf[j] = 1'b1;
        end else begin
          w_cnt_nxt[j] = r_cnt[j] - CntW'(1);
        end
      end
      if (w_cnt_nxt[j] != '0) begin
        w_all_zero = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_all_zero) w_state_nxt = FLUSH_REQ;
      end
      FLUSH_REQ: begin
        if (cache_flush_ready_i) begin
          w_state_nxt = cache_flush_done_i ? COMMIT : FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (cache_flush_done_i) w_state_nxt = COMMIT;
      end
      COMMIT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o         = w_idle;
    busy_o              = ~w_idle;
    cache_flush_valid_o = (r_state == FLUSH_REQ);
    for (int j = 0; j < NumIO; j++) begin
      stall_o[j] = ~w_idle | (r_cnt[j] == CntMax);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < NumIO; j++) begin
        r_cnt[j] <= '0;
      end
      r_spm     <= SpmSizeReset;
      r_pending <= '0;
      r_cfg_err <= 1'b0;
      r_uf      <= 1'b0;
    end else begin
      for (int j = 0; j < NumIO; j++) begin
        r_cnt[j] <= w_cnt_nxt[j];
      end
      r_cfg_err <= w_cfg_hs & ~w_size_ok;
      r_uf      <= r_uf | (|w_uf);
      if (w_accept) begin
        r_pending <= cfg_spm_size_i;
      end
      if (r_state == COMMIT) begin
        r_spm <= r_pending;
      end
    end
  end

  assign spm_size_o  = r_spm;
  assign cfg_error_o = r_cfg_err;
  assign underflow_o = r_uf;

endmodule

// File: tb/tb_spatz_spm_partition_ctrl.sv
// Bench for spatz_spm_partition_ctrl: directed scenarios plus
// randomized traffic against a flag-based reference model.
module tb_spatz_spm_partition_ctrl;

  localparam int NIO = 4;
  localparam int MAXO = 8;
  localparam logic [31:0] RST_SIZE = 32'h0001_0000;
  localparam logic [31:0] START = 32'h1000_0000;
  localparam logic [31:0] REGION = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid;
  logic cfg_ready;
  logic [31:0] cfg_size;
  logic [31:0] t_start;
  logic [31:0] t_end;
  logic [31:0] spm_size;
  logic [NIO-1:0] req_valid;
  logic [NIO-1:0] req_ready;
  logic [NIO-1:0] rsp_valid;
  logic [NIO-1:0] stall;
  logic fl_valid;
  logic fl_ready;
  logic fl_done;
  logic busy;
  logic cfg_err;
  logic uflow;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  spatz_spm_partition_ctrl #(
    .NumIO(NIO),
    .AddrWidth(32),
    .MaxOutstanding(MAXO),
    .SizeGranule(1024),
    .SpmSizeReset(RST_SIZE)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_spm_size_i(cfg_size),
    .tcdm_start_address_i(t_start),
    .tcdm_end_address_i(t_end),
    .spm_size_o(spm_size),
    .req_valid_i(req_valid),
    .req_ready_i(req_ready),
    .rsp_valid_i(rsp_valid),
    .stall_o(stall),
    .cache_flush_valid_o(fl_valid),
    .cache_flush_ready_i(fl_ready),
    .cache_flush_done_i(fl_done),
    .busy_o(busy),
    .cfg_error_o(cfg_err),
    .underflow_o(uflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a reconfiguration is a sequence of milestones
  // (drained, flush accepted, flush done) followed by the commit.
  int m_cnt [NIO];
  bit m_busy, m_drained, m_acc, m_flushed, m_err, m_uf;
  logic [31:0] m_spm, m_pend;

  function automatic logic [NIO-1:0] m_stall();
    logic [NIO-1:0] s;
    for (int j = 0; j < NIO; j++) s[j] = m_busy || (m_cnt[j] == MAXO);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NIO; j++) m_cnt[j] = 0;
      m_busy = 0; m_drained = 0; m_acc = 0; m_flushed = 0;
      m_err = 0; m_uf = 0; m_spm = RST_SIZE; m_pend = 0;
    end else begin
      bit zero;
      bit ok;
      zero = 1;
      for (int j = 0; j < NIO; j++) begin
        bit inc;
        inc = req_valid[j] && req_ready[j];
        if (inc && !rsp_valid[j]) m_cnt[j]++;
        else if (!inc && rsp_valid[j]) begin
          if (m_cnt[j] == 0) m_uf = 1;
          else m_cnt[j]--;
        end
        if (m_cnt[j] != 0) zero = 0;
      end
      m_err = 0;
      if (!m_busy) begin
        if (cfg_valid) begin
          ok = (cfg_size <= t_end - t_start) && (cfg_size % 1024 == 0);
          if (!ok) m_err = 1;
          else if (cfg_size != m_spm) begin
            m_busy = 1; m_pend = cfg_size;
            m_drained = 0; m_acc = 0; m_flushed = 0;
          end
        end
      end else if (!m_drained) begin
        if (zero) m_drained = 1;
      end else if (!m_acc) begin
        if (fl_ready) begin
          m_acc = 1;
          if (fl_done) m_flushed = 1;
        end
      end else if (!m_flushed) begin
        if (fl_done) m_flushed = 1;
      end else begin
        m_spm = m_pend;
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("mon_spm", spm_size, m_spm);
      check("mon_stall", 32'(stall), 32'(m_stall()));
      check("mon_ready", 32'(cfg_ready), 32'(!m_busy));
      check("mon_busy", 32'(busy), 32'(m_busy));
      check("mon_flv", 32'(fl_valid), 32'(m_busy && m_drained && !m_acc));
      check("mon_err", 32'(cfg_err), 32'(m_err));
      check("mon_uf", 32'(uflow), 32'(m_uf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    cfg_valid = 0; req_valid = 0; req_ready = 0; rsp_valid = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_spm"}, spm_size, RST_SIZE);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_flv"}, 32'(fl_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_uf"}, 32'(uflow), 32'd0);
  endtask

  initial begin
    logic [31:0] bad [2];
    clr();
    cfg_size = 0; fl_ready = 0; fl_done = 0;
    t_start = START; t_end = START + REGION;
    bad[0] = 32'h0000_0300;
    bad[1] = REGION + 32'h1000;
    #12;
    chk_reset_vals("rst");
    #10 rst_n = 1;
    mon_en = 1;

    // minimum latency path
    tick(); cfg_valid = 1; cfg_size = 32'h8000; fl_ready = 1; fl_done = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(); cfg_valid = 0;
      @(negedge clk);
      if (k < 4) begin
        check("a_stall", 32'(stall), 32'hF);
        check("a_spm_old", spm_size, RST_SIZE);
      end else begin
        check("a_spm_new", spm_size, 32'h8000);
        check("a_stall_rel", 32'(stall), 32'h0);
      end
      if (k == 2) check("a_flv", 32'(fl_valid), 32'd1);
    end

    // port 2 with three outstanding
    for (int k = 0; k < 3; k++) begin
      tick(); req_valid = 4'b0100; req_ready = 4'b0100;
    end
    for (int k = 0; k <= 10; k++) begin
      tick();
      req_valid = 0; req_ready = 0;
      cfg_valid = (k == 0); cfg_size = 32'hC000;
      rsp_valid = (k >= 5 && k <= 7) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (k <= 9) check("b_spm_old", spm_size, 32'h8000);
      if (k == 7) check("b_flv_early", 32'(fl_valid), 32'd0);
      if (k == 8) check("b_flv", 32'(fl_valid), 32'd1);
      if (k == 10) check("b_spm_new", spm_size, 32'hC000);
    end
    clr();

    // rejected sizes and equal-size no-op
    for (int i = 0; i < 2; i++) begin
      tick(); cfg_valid = 1; cfg_size = bad[i];
      @(negedge clk); check("c_err_pre", 32'(cfg_err), 32'd0);
      tick(); cfg_valid = 0;
      @(negedge clk);
      check("c_err", 32'(cfg_err), 32'd1);
      check("c_busy", 32'(busy), 32'd0);
      tick();
      @(negedge clk);
      check("c_err_post", 32'(cfg_err), 32'd0);
      check("c_spm", spm_size, 32'hC000);
    end
    tick(); cfg_valid = 1; cfg_size = 32'hC000;
    tick(); cfg_valid = 0;
    @(negedge clk);
    check("c_noop_busy", 32'(busy), 32'd0);
    check("c_noop_err", 32'(cfg_err), 32'd0);

    // port 0 saturation at MaxOutstanding
    for (int k = 0; k < 8; k++) begin
      tick(); req_valid = 4'b0001; req_ready = 4'b0001;
      @(negedge clk); check("d_stall_lo", 32'(stall[0]), 32'd0);
    end
    tick(); rsp_valid = 4'b0001;
    @(negedge clk); check("d_stall_full", 32'(stall[0]), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick(); req_valid = 0; req_ready = 0; rsp_valid = 4'b0001;
      @(negedge clk); check("d_stall_rsp", 32'(stall[0]), 32'(k == 0));
    end
    tick(); clr();
    @(negedge clk);
    check("d_stall_end", 32'(stall[0]), 32'd0);
    check("d_uf", 32'(uflow), 32'd0);

    // underflow on port 1
    tick(); rsp_valid = 4'b0010;
    tick(); rsp_valid = 0;
    @(negedge clk); check("e_uf", 32'(uflow), 32'd1);
    tick();
    @(negedge clk); check("e_uf_hold", 32'(uflow), 32'd1);

    // reset while waiting for the flush to finish
    tick(); cfg_valid = 1; cfg_size = 32'h4000; fl_ready = 1; fl_done = 0;
    tick(); cfg_valid = 0;
    tick();
    tick();
    @(negedge clk);
    check("f_busy", 32'(busy), 32'd1);
    check("f_flv", 32'(fl_valid), 32'd0);
    #2 rst_n = 0;
    #1 chk_reset_vals("f_rst");
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1;
    fl_done = 1;
    tick();
    @(negedge clk);
    check("f_discard", spm_size, RST_SIZE);
    check("f_idle", 32'(busy), 32'd0);
    for (int k = 0; k <= 4; k++) begin
      tick(); cfg_valid = (k == 0); cfg_size = 32'h4000;
      @(negedge clk);
      check("f_seq_spm", spm_size, (k == 4) ? 32'h4000 : RST_SIZE);
    end

    // randomized traffic and configuration
    for (int i = 0; i < 3000; i++) begin
      logic [NIO-1:0] st;
      tick();
      st = m_stall();
      cfg_valid = ($urandom % 8 == 0);
      case ($urandom % 4)
        0: cfg_size = 32'($urandom_range(0, 128)) * 32'd1024;
        1: cfg_size = 32'($urandom_range(0, 127)) * 32'd1024 +
                      32'($urandom_range(1, 1023));
        2: cfg_size = REGION + 32'($urandom_range(1, 16)) * 32'd1024;
        default: cfg_size = m_spm;
      endcase
      for (int j = 0; j < NIO; j++) begin
        req_valid[j] = ($urandom % 2 == 0) && !st[j];
        req_ready[j] = ($urandom % 3 != 0);
        rsp_valid[j] = (m_cnt[j] > 0) && ($urandom % 3 == 0);
      end
      fl_ready = ($urandom % 2 == 0);
      fl_done = ($urandom % 4 == 0);
    end
    tick(); clr();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
